ibex_xif_icache_core_stream_checker: RTL and testbench

- Synthesisable, parametrised checker for the core-side fetch port of the icache; passive, observes only.
- Successor to the testbench-only protocol checks: it tracks the expected fetch address across branches, compressed instructions and errors, and keeps saturating event counters.
- Sits beside the icache in FPGA/emulation builds and in the UVM bench.
- Flags are readable by software or by the bench scoreboard.

---
 rtl/ibex_xif_icache_core_stream_checker.sv | 146 ++++++++++++++
 tb/tb_ibex_xif_icache_core_stream_checker.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/ibex_xif_icache_core_stream_checker.sv
// Passive checker for the icache core-side fetch stream: follows the expected fetch
// address, raises sticky protocol flags and keeps saturating event counters.
module ibex_xif_icache_core_stream_checker #(
  parameter int ADDR_W        = 32,
  parameter int DATA_W        = 32,
  parameter int CNT_W         = 16,
  parameter bit COMPRESSED_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              branch,
  input  logic [ADDR_W-1:0] branch_addr,
  input  logic              ready,
  input  logic              valid,
  input  logic [DATA_W-1:0] rdata,
  input  logic [ADDR_W-1:0] addr,
  input  logic              err,
  input  logic              clear,
  output logic              mismatch_o,
  output logic              unstable_o,
  output logic              align_o,
  output logic              post_err_o,
  output logic              early_valid_o,
  output logic              any_err_o,
  output logic [CNT_W-1:0]  fetch_cnt_o,
  output logic [CNT_W-1:0]  cancel_cnt_o
);

  typedef enum logic [1:0] {IDLE, TRACK, ERR_HOLD} state_t;

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] exp_reg, exp_next;

  logic              stall_reg;
  logic [ADDR_W-1:0] stall_addr_reg;
  logic [DATA_W-1:0] stall_rdata_reg;
  logic              stall_err_reg;
  logic              cancel_pend_reg;

  logic              mismatch_reg, unstable_reg, align_reg, post_err_reg, early_valid_reg;
  logic [CNT_W-1:0]  fetch_cnt_reg, cancel_cnt_reg;

  logic              accept;
  logic              compressed;
  logic [ADDR_W-1:0] step_addr;
  logic              ev_mismatch, ev_unstable, ev_align, ev_post_err, ev_early;
  logic              ev_cancel;

  // A fetch coinciding with a branch belongs to the abandoned stream and is ignored.
  assign accept     = valid & ready & ~branch;
  assign compressed = COMPRESSED_EN && (rdata[1:0] != 2'b11);
  assign step_addr  = addr + (compressed ? ADDR_W'(2) : ADDR_W'(4));

  always_comb begin
    state_next  = state_reg;
    exp_next    = exp_reg;
    ev_mismatch = 1'b0;
    ev_align    = 1'b0;
    ev_post_err = 1'b0;
    ev_early    = 1'b0;
    if (branch) begin
      state_next = TRACK;
      exp_next   = branch_addr;
      ev_align   = branch_addr[0];
    end else begin
      case (state_reg)
        IDLE:     ev_early = valid & req;
        TRACK: begin
          if (accept) begin
            if (err) begin
              state_next = ERR_HOLD;
            end else begin
              ev_mismatch = (addr != exp_reg);
              // Re-anchor on the observed address so a single skip flags only once.
              exp_next    = step_addr;
            end
          end
        end
        ERR_HOLD: ev_post_err = accept;
        default:  state_next = IDLE;
      endcase
    end
  end

  assign ev_unstable = stall_reg & ~branch &
                       (~valid | (addr != stall_addr_reg) |
                        (rdata != stall_rdata_reg) | (err != stall_err_reg));
  assign ev_cancel   = cancel_pend_reg & ~valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= IDLE;
      exp_reg         <= '0;
      stall_reg       <= 1'b0;
      stall_addr_reg  <= '0;
      stall_rdata_reg <= '0;
      stall_err_reg   <= 1'b0;
      cancel_pend_reg <= 1'b0;
      mismatch_reg    <= 1'b0;
      unstable_reg    <= 1'b0;
      align_reg       <= 1'b0;
      post_err_reg    <= 1'b0;
      early_valid_reg <= 1'b0;
      fetch_cnt_reg   <= '0;
      cancel_cnt_reg  <= '0;
    end else begin
      state_reg       <= state_next;
      exp_reg         <= exp_next;
      stall_reg       <= valid & ~ready & ~branch;
      stall_addr_reg  <= addr;
      stall_rdata_reg <= rdata;
      stall_err_reg   <= err;
      cancel_pend_reg <= valid & ~ready & branch;
      if (clear) begin
        mismatch_reg    <= 1'b0;
        unstable_reg    <= 1'b0;
        align_reg       <= 1'b0;
        post_err_reg    <= 1'b0;
        early_valid_reg <= 1'b0;
        fetch_cnt_reg   <= '0;
        cancel_cnt_reg  <= '0;
      end else begin
        mismatch_reg    <= mismatch_reg    | ev_mismatch;
        unstable_reg    <= unstable_reg    | ev_unstable;
        align_reg       <= align_reg       | ev_align;
        post_err_reg    <= post_err_reg    | ev_post_err;
        early_valid_reg <= early_valid_reg | ev_early;
        if (accept && (fetch_cnt_reg != {CNT_W{1'b1}}))
          fetch_cnt_reg <= fetch_cnt_reg + CNT_W'(1);
        if (ev_cancel && (cancel_cnt_reg != {CNT_W{1'b1}}))
          cancel_cnt_reg <= cancel_cnt_reg + CNT_W'(1);
      end
    end
  end

  assign mismatch_o    = mismatch_reg;
  assign unstable_o    = unstable_reg;
  assign align_o       = align_reg;
  assign post_err_o    = post_err_reg;
  assign early_valid_o = early_valid_reg;
  assign any_err_o     = mismatch_reg | unstable_reg | align_reg | post_err_reg | early_valid_reg;
  assign fetch_cnt_o   = fetch_cnt_reg;
  assign cancel_cnt_o  = cancel_cnt_reg;

endmodule

// File: tb/tb_ibex_xif_icache_core_stream_checker.sv
// Directed bench for the fetch stream checker; a second instance with 2-bit counters
// shares the stimulus to exercise saturation.
module tb_ibex_xif_icache_core_stream_checker;

  logic        clk = 1'b0;
  logic        rst, req, branch, ready, valid, err, clear;
  logic [31:0] branch_addr, rdata, addr;

  logic        mismatch_o, unstable_o, align_o, post_err_o, early_valid_o, any_err_o;
  logic [15:0] fetch_cnt_o, cancel_cnt_o;
  logic        b_mismatch, b_unstable, b_align, b_post_err, b_early, b_any;
  logic [1:0]  b_fetch_cnt, b_cancel_cnt;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ibex_xif_icache_core_stream_checker dut (
    .clk(clk), .rst(rst), .req(req), .branch(branch), .branch_addr(branch_addr),
    .ready(ready), .valid(valid), .rdata(rdata), .addr(addr), .err(err), .clear(clear),
    .mismatch_o(mismatch_o), .unstable_o(unstable_o), .align_o(align_o),
    .post_err_o(post_err_o), .early_valid_o(early_valid_o), .any_err_o(any_err_o),
    .fetch_cnt_o(fetch_cnt_o), .cancel_cnt_o(cancel_cnt_o)
  );

  ibex_xif_icache_core_stream_checker #(.CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .req(req), .branch(branch), .branch_addr(branch_addr),
    .ready(ready), .valid(valid), .rdata(rdata), .addr(addr), .err(err), .clear(clear),
    .mismatch_o(b_mismatch), .unstable_o(b_unstable), .align_o(b_align),
    .post_err_o(b_post_err), .early_valid_o(b_early), .any_err_o(b_any),
    .fetch_cnt_o(b_fetch_cnt), .cancel_cnt_o(b_cancel_cnt)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic do_branch(input logic [31:0] target);
    branch = 1'b1; branch_addr = target;
    step();
    branch = 1'b0;
  endtask

  task automatic fetch(input logic [31:0] a, input logic [31:0] d, input logic e);
    valid = 1'b1; ready = 1'b1; addr = a; rdata = d; err = e;
    step();
    valid = 1'b0; ready = 1'b0; err = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    step();
    clear = 1'b0;
  endtask

  initial begin
    rst = 1'b1; req = 1'b0; branch = 1'b0; ready = 1'b0; valid = 1'b0; err = 1'b0;
    clear = 1'b0; branch_addr = '0; rdata = '0; addr = '0;
    step(); step();
    rst = 1'b0;
    check("reset_any_err", any_err_o, 0);
    check("reset_fetch_cnt", fetch_cnt_o, 0);
    check("reset_cancel_cnt", cancel_cnt_o, 0);

    // Straight-line 32-bit instructions
    req = 1'b1;
    do_branch(32'h100);
    for (int i = 0; i < 4; i++) fetch(32'h100 + 32'(4 * i), 32'h0000_0013, 1'b0);
    step();
    check("seq_any_err", any_err_o, 0);
    check("seq_fetch_cnt", fetch_cnt_o, 4);
    check("sat_fetch_cnt", b_fetch_cnt, 3);

    // Compressed step then a skipped halfword
    do_branch(32'h200);
    fetch(32'h200, 32'h0000_0001, 1'b0);
    fetch(32'h202, 32'h0000_0013, 1'b0);
    check("compressed_no_mismatch", mismatch_o, 0);
    fetch(32'h208, 32'h0000_0013, 1'b0);
    check("skip_mismatch", mismatch_o, 1);
    check("skip_any_err", any_err_o, 1);
    do_clear();
    check("clear_mismatch", mismatch_o, 0);
    check("clear_fetch_cnt", fetch_cnt_o, 0);

    // Address changes during a stall
    do_branch(32'h300);
    valid = 1'b1; ready = 1'b0; addr = 32'h300; rdata = 32'h13;
    step();
    addr = 32'h304;
    step();
    check("stall_unstable", unstable_o, 1);
    valid = 1'b0;
    do_clear();
    check("clear_unstable", unstable_o, 0);
    step();
    check("clear_drops_event", unstable_o, 0);

    // Stall cancelled by a branch, then a clean stall resolved by acceptance
    valid = 1'b1; ready = 1'b0; addr = 32'h300; branch = 1'b1; branch_addr = 32'h300;
    step();
    branch = 1'b0; valid = 1'b0;
    step();
    check("cancel_no_unstable", unstable_o, 0);
    check("cancel_cnt", cancel_cnt_o, 1);
    valid = 1'b1; ready = 1'b0; addr = 32'h300; rdata = 32'h13;
    step();
    ready = 1'b1;
    step();
    valid = 1'b0; ready = 1'b0;
    step();
    check("stable_stall_unstable", unstable_o, 0);
    check("stable_stall_mismatch", mismatch_o, 0);

    // Fetch after error without branch
    do_branch(32'h500);
    fetch(32'h500, 32'h13, 1'b1);
    fetch(32'h504, 32'h13, 1'b0);
    check("post_err_flag", post_err_o, 1);
    do_clear();
    do_branch(32'h600);
    fetch(32'h600, 32'h13, 1'b0);
    check("post_err_recovered", post_err_o, 0);
    check("post_err_mismatch", mismatch_o, 0);
    check("post_err_fetch_cnt", fetch_cnt_o, 1);

    // Mid-run reset, then pre-branch valid and misaligned branch
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("midrst_fetch_cnt", fetch_cnt_o, 0);
    check("midrst_cancel_cnt", cancel_cnt_o, 0);
    req = 1'b0;
    fetch(32'h0, 32'h13, 1'b0);
    check("req_low_no_early", early_valid_o, 0);
    req = 1'b1;
    fetch(32'h0, 32'h13, 1'b0);
    check("early_valid", early_valid_o, 1);
    do_branch(32'h401);
    check("align_flag", align_o, 1);
    check("align_any_err", any_err_o, 1);
    do_clear();
    check("clear_align", align_o, 0);
    check("clear_early", early_valid_o, 0);
    check("clear_any_err", any_err_o, 0);

    // Address wrap at the top of the space
    do_branch(32'hFFFF_FFFC);
    fetch(32'hFFFF_FFFC, 32'h13, 1'b0);
    fetch(32'h0000_0000, 32'h13, 1'b0);
    fetch(32'h0000_0004, 32'h13, 1'b0);
    fetch(32'h0000_0008, 32'h13, 1'b0);
    fetch(32'h0000_000C, 32'h13, 1'b0);
    check("wrap_mismatch", mismatch_o, 0);
    check("wrap_fetch_cnt", fetch_cnt_o, 5);
    check("wrap_sat_fetch_cnt", b_fetch_cnt, 3);
    check("wrap_sat_mismatch", b_mismatch, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
